ddr2_pattern_engine: RTL and testbench
======================================

Name: ddr2_pattern_engine

Overview:
- Parametrised, self-checking traffic engine for the DDR2 controller.
- Replaces file-driven pattern injection with on-the-fly generation: a write phase of block writes, then a read-back phase of block reads, with every returned word checked against the expected value.
- Sits between the bench top and ddr2_controller. It drives the controller's command port (CMD/SZ/OP/DIN/ADDR/FETCHING) and monitors the return port (DOUT/RADDR/VALIDOUT).
- Reports pass/fail, error count and first failing address.

Parameters:
- DATA_W, 16, data word width (DIN/DOUT).
- ADDR_W, 25, word address width (ADDR/RADDR).
- NUM_BLOCKS, 64, blocks written then read per pass; range 1..4096.
- BLK_SZ, 2'b11, SZ code driven on every block command; block length = (BLK_SZ+1)*8 words.
- BASE_ADDR, 0, first block address; must be aligned to the block length.
- ADDR_MODE, 0, 0 = sequential blocks, 1 = 16-bit LFSR block index (x^16+x^14+x^13+x^11+1, seed 16'hACE1).
- FILL_THRESH, 96, new beats are issued only while fillcount < FILL_THRESH.
- TIMEOUT, 4096, idle cycles allowed in WAIT_RD before declaring timeout.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse; sampled only in IDLE while ready=1.
- seed, input, DATA_W, data-pattern seed, latched on start.
- ready, input, 1, controller initialisation complete.
- cmd, output, 3, 3'b000 NOP, 3'b011 block read, 3'b100 block write.
- sz, output, 2, block size code.
- op, output, 3, always 3'b000.
- fetching, output, 1, beat valid.
- din, output, DATA_W, write data.
- addr, output, ADDR_W, block start address.
- fillcount, input, 7, controller input-FIFO occupancy.
- notfull, input, 1, controller can accept a beat.
- dout, input, DATA_W, read data.
- raddr, input, ADDR_W, address of dout.
- validout, input, 1, dout/raddr valid.
- busy, output, 1, high in any state other than IDLE/DONE.
- done, output, 1, level; high in DONE.
- pass, output, 1, valid when done=1; 1 iff err_count==0 and no timeout.
- err_count, output, 16, saturating count of mismatches.
- first_err_addr, output, ADDR_W, raddr of the first mismatch.
- timeout, output, 1, sticky; set on read-back timeout.

Behaviour:
- Reset (async, reset=0): state IDLE; cmd/sz/op/din/addr=0; fetching=0; busy=0; done=0; pass=0; err_count=0; first_err_addr=0; timeout=0; all counters=0.
- Beat transfer: occurs on a posedge with fetching=1 && notfull=1.
- Hold rule: outputs are held stable while fetching=1 && notfull=0.
- Issue gating: a new beat is raised only if fillcount < FILL_THRESH.
- Expected data: E(a) = a[15:0] ^ seed ^ {a[24:16], 7'b0}.
- Write block: L = (BLK_SZ+1)*8 beats. Each beat carries cmd=100, addr = block start, din = E(start+i) for i = 0..L-1.
- Read block: a single beat with cmd=011 and addr = block start. outstanding += L on acceptance.
- Block address:
  - ADDR_MODE=0: BASE_ADDR + k*L.
  - ADDR_MODE=1: BASE_ADDR + (lfsr mod NUM_BLOCKS)*L, where lfsr advances per block.
  - The read phase reseeds the LFSR, so it revisits the same order as the write phase.
- FSM:
  - IDLE -> WR on start&&ready; latch seed; clear err_count, first_err_addr, timeout, done.
  - WR -> RD after the last beat of block NUM_BLOCKS-1 is accepted.
  - RD -> WAIT_RD after the last read beat is accepted.
  - WAIT_RD -> DONE when outstanding==0, or when the idle counter reaches TIMEOUT (sets timeout).
  - DONE -> WR on start&&ready (new run); otherwise hold.
- Checker: active in RD and WAIT_RD.
  - Each validout cycle decrements outstanding and compares dout with E(raddr).
  - On mismatch, err_count increments, saturating at 16'hFFFF.
  - first_err_addr captures raddr only when err_count==0.
  - validout while outstanding==0 counts as an error and does not decrement.
- Idle counter: cleared on every validout; increments in WAIT_RD otherwise.
- Simultaneous read-beat acceptance and validout in one cycle: outstanding += L-1.
- Outputs after the last beat: cmd returns to NOP and fetching=0 in the cycle after the last accepted beat.
- Ignored inputs: start in WR/RD/WAIT_RD; validout in IDLE/WR/DONE.
- ready dropping mid-run: no effect; the run continues.
- Reset mid-run: immediate return to IDLE; pending reads are discarded.

Test Plan:
- Sequential run: NUM_BLOCKS=4, BLK_SZ=3, seed=16'h5A5A, ideal controller model, notfull=1 -> 128 write beats, then 4 read beats at addr 0/32/64/96; done=1, pass=1, err_count=0.
- Backpressure: notfull toggles every 3 cycles and fillcount=100 for 20 cycles -> no beat issued while fillcount>=96; outputs held during stalls; beat count exactly 4*32+4.
- Corruption: model flips bit 0 of the word at raddr=37 and at raddr=70 -> err_count=2, first_err_addr=37, pass=0.
- LFSR order: ADDR_MODE=1, NUM_BLOCKS=8 -> read addresses match the write-address sequence in order; all 8 blocks are distinct modulo collisions; pass=1.
- Timeout: model drops the last 5 read words -> after TIMEOUT idle cycles, timeout=1, done=1, pass=0.
- Reset and restart: assert reset=0 mid-WR -> all outputs go to reset values asynchronously; a new start completes cleanly with pass=1.

Source files
------------

// File: rtl/ddr2_pattern_engine_if.sv
// Command/return bus between the pattern engine and the DDR2 controller.
// The engine is the master; the controller (or its bench model) is the slave.
interface ddr2_pattern_engine_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 25
);
    logic [2:0]        cmd;
    logic [1:0]        sz;
    logic [2:0]        op;
    logic              fetching;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] addr;
    logic              ready;
    logic [6:0]        fillcount;
    logic              notfull;
    logic [DATA_W-1:0] dout;
    logic [ADDR_W-1:0] raddr;
    logic              validout;

    modport master (
        output cmd, sz, op, fetching, din, addr,
        input  ready, fillcount, notfull, dout, raddr, validout
    );

    modport slave (
        input  cmd, sz, op, fetching, din, addr,
        output ready, fillcount, notfull, dout, raddr, validout
    );
endinterface

// File: rtl/ddr2_pattern_engine.sv
// Self-checking DDR2 traffic engine: writes NUM_BLOCKS blocks of address-derived
// data, reads them back in the same block order and checks every returned word.
//
// state   | meaning
// S_IDLE  | waiting for start after reset
// S_WR    | issuing block-write beats
// S_RD    | issuing one block-read beat per block
// S_WAIT_RD | draining outstanding read words, idle timer running
// S_DONE  | result valid; start launches a new run
module ddr2_pattern_engine #(
    parameter int          DATA_W      = 16,
    parameter int          ADDR_W      = 25,
    parameter int          NUM_BLOCKS  = 64,
    parameter logic [1:0]  BLK_SZ      = 2'b11,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int          ADDR_MODE   = 0,
    parameter int          FILL_THRESH = 96,
    parameter int          TIMEOUT     = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [DATA_W-1:0]    seed_i,
    ddr2_pattern_engine_if.master bus,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [15:0]          err_count_o,
    output logic [ADDR_W-1:0]    first_err_addr_o,
    output logic                 timeout_o
);
    localparam int          BLK_LEN   = (int'(BLK_SZ) + 1) * 8;
    localparam int          OUT_W     = 20;
    localparam int          IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [5:0]  BEAT_LAST = 6'(BLK_LEN - 1);
    localparam logic [12:0] BLK_LAST  = 13'(NUM_BLOCKS - 1);
    localparam logic [7:0]  FILL_T    = 8'(FILL_THRESH);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [2:0]  CMD_NOP   = 3'b000;
    localparam logic [2:0]  CMD_RD    = 3'b011;
    localparam logic [2:0]  CMD_WR    = 3'b100;

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_WAIT_RD, S_DONE} state_t;

    state_t              state_q;
    logic [2:0]          cmd_q;
    logic [1:0]          sz_q;
    logic                fetching_q;
    logic [DATA_W-1:0]   din_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   seed_q;
    logic [5:0]          beat_q;
    logic [12:0]         blk_q;
    logic                last_q;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [OUT_W-1:0]    outstanding_q, outstanding_d;
    logic [IDLE_W-1:0]   idle_q;
    logic                busy_q, done_q, pass_q, timeout_q;
    logic [15:0]         err_count_q;
    logic [ADDR_W-1:0]   first_err_addr_q;

    logic [15:0]         blk_idx;
    logic [ADDR_W-1:0]   blk_addr;
    logic                accept, can_raise, fill_ok, chk_v, chk_err;

    // E(a) = a[15:0] ^ seed ^ {a[24:16], 7'b0}
    function automatic logic [DATA_W-1:0] exp_word(input logic [ADDR_W-1:0] a,
                                                   input logic [DATA_W-1:0] s);
        logic [15:0] e;
        e = 16'(a) ^ 16'((32'(a) >> 16) << 7);
        return DATA_W'(e) ^ s;
    endfunction

    always_comb begin
        lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        blk_idx   = (ADDR_MODE == 1) ? (lfsr_q % 16'(NUM_BLOCKS)) : 16'(blk_q);
        blk_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(blk_idx) * ADDR_W'(BLK_LEN);
        accept    = fetching_q && bus.notfull;
        can_raise = !fetching_q || bus.notfull;
        fill_ok   = {1'b0, bus.fillcount} < FILL_T;
        chk_v     = (state_q == S_RD || state_q == S_WAIT_RD) && bus.validout;
        chk_err   = chk_v && ((outstanding_q == '0) ||
                              (bus.dout != exp_word(bus.raddr, seed_q)));
        outstanding_d = outstanding_q;
        if (state_q == S_RD && accept)
            outstanding_d = outstanding_d + OUT_W'(BLK_LEN);
        // A stray word with nothing outstanding is an error, not a credit.
        if (chk_v && outstanding_q != '0)
            outstanding_d = outstanding_d - OUT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            cmd_q            <= CMD_NOP;
            sz_q             <= 2'b00;
            fetching_q       <= 1'b0;
            din_q            <= '0;
            addr_q           <= '0;
            seed_q           <= '0;
            beat_q           <= '0;
            blk_q            <= '0;
            last_q           <= 1'b0;
            lfsr_q           <= '0;
            outstanding_q    <= '0;
            idle_q           <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            timeout_q        <= 1'b0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            if (chk_err) begin
                if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
                if (err_count_q == 16'd0)    first_err_addr_q <= bus.raddr;
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i && bus.ready) begin
                        state_q          <= S_WR;
                        seed_q           <= seed_i;
                        err_count_q      <= '0;
                        first_err_addr_q <= '0;
                        timeout_q        <= 1'b0;
                        done_q           <= 1'b0;
                        pass_q           <= 1'b0;
                        busy_q           <= 1'b1;
                        beat_q           <= '0;
                        blk_q            <= '0;
                        last_q           <= 1'b0;
                        lfsr_q           <= LFSR_SEED;
                        outstanding_q    <= '0;
                        idle_q           <= '0;
                    end
                end
                S_WR, S_RD: begin
                    if (accept && last_q) begin
                        fetching_q <= 1'b0;
                        cmd_q      <= CMD_NOP;
                        last_q     <= 1'b0;
                        beat_q     <= '0;
                        blk_q      <= '0;
                        // Reseed so the read phase revisits the write order.
                        lfsr_q     <= LFSR_SEED;
                        state_q    <= (state_q == S_WR) ? S_RD : S_WAIT_RD;
                    end else if (can_raise) begin
                        if (!last_q && fill_ok) begin
                            fetching_q <= 1'b1;
                            sz_q       <= BLK_SZ;
                            addr_q     <= blk_addr;
                            if (state_q == S_WR) begin
                                cmd_q <= CMD_WR;
                                din_q <= exp_word(blk_addr + ADDR_W'(beat_q), seed_q);
                            end else begin
                                cmd_q <= CMD_RD;
                                din_q <= '0;
                            end
                            if (state_q == S_RD || beat_q == BEAT_LAST) begin
                                beat_q <= '0;
                                blk_q  <= blk_q + 13'd1;
                                lfsr_q <= lfsr_d;
                                if (blk_q == BLK_LAST) last_q <= 1'b1;
                            end else begin
                                beat_q <= beat_q + 6'd1;
                            end
                        end else begin
                            fetching_q <= 1'b0;
                            cmd_q      <= CMD_NOP;
                        end
                    end
                end
                S_WAIT_RD: begin
                    if (outstanding_q == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        pass_q  <= !chk_err && (err_count_q == 16'd0);
                    end else if (idle_q == IDLE_W'(TIMEOUT)) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        pass_q    <= 1'b0;
                    end else begin
                        idle_q <= bus.validout ? '0 : idle_q + IDLE_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd          = cmd_q;
    assign bus.sz           = sz_q;
    assign bus.op           = 3'b000;
    assign bus.fetching     = fetching_q;
    assign bus.din          = din_q;
    assign bus.addr         = addr_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_count_o      = err_count_q;
    assign first_err_addr_o = first_err_addr_q;
    assign timeout_o        = timeout_q;
endmodule

// File: tb/tb_ddr2_pattern_engine.sv
// Directed bench for ddr2_pattern_engine with a small ideal DDR2 controller model
// that can stall, corrupt and drop returned words.
module tb_ddr2_pattern_engine;
    localparam int L = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0;
    logic [15:0] seed = '0, seed_cur = '0;
    logic sel = 1'b0;

    logic ready = 1'b1, notfull = 1'b1, validout = 1'b0;
    logic [6:0] fillcount = '0;
    logic [15:0] dout = '0;
    logic [24:0] raddr = '0;

    logic busy0, done0, pass0, tmo0, busy1, done1, pass1, tmo1;
    logic [15:0] err0, err1;
    logic [24:0] ferr0, ferr1;

    ddr2_pattern_engine_if #(.DATA_W(16), .ADDR_W(25)) bus0 ();
    ddr2_pattern_engine_if #(.DATA_W(16), .ADDR_W(25)) bus1 ();

    assign bus0.ready = ready;     assign bus1.ready = ready;
    assign bus0.notfull = notfull; assign bus1.notfull = notfull;
    assign bus0.fillcount = fillcount; assign bus1.fillcount = fillcount;
    assign bus0.dout = dout;       assign bus1.dout = dout;
    assign bus0.raddr = raddr;     assign bus1.raddr = raddr;
    assign bus0.validout = validout; assign bus1.validout = validout;

    ddr2_pattern_engine #(.NUM_BLOCKS(4), .BLK_SZ(2'b11), .ADDR_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .start_i(start0), .seed_i(seed), .bus(bus0),
        .busy_o(busy0), .done_o(done0), .pass_o(pass0), .err_count_o(err0),
        .first_err_addr_o(ferr0), .timeout_o(tmo0));

    ddr2_pattern_engine #(.NUM_BLOCKS(8), .BLK_SZ(2'b11), .ADDR_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .start_i(start1), .seed_i(seed), .bus(bus1),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_count_o(err1),
        .first_err_addr_o(ferr1), .timeout_o(tmo1));

    always #5 clk = ~clk;

    logic m_fet, cur_done;
    logic [2:0] m_cmd, m_op;
    logic [24:0] m_addr;
    logic [15:0] m_din;
    assign m_fet    = sel ? bus1.fetching : bus0.fetching;
    assign m_cmd    = sel ? bus1.cmd : bus0.cmd;
    assign m_op     = sel ? bus1.op : bus0.op;
    assign m_addr   = sel ? bus1.addr : bus0.addr;
    assign m_din    = sel ? bus1.din : bus0.din;
    assign cur_done = sel ? done1 : done0;

    int n_checks = 0, n_fail = 0;
    int cyc, wr_beats, rd_beats, wr_err, proto_err, hold_viol, fill_viol, ret_cnt, wr_i;
    int ret_limit = 1 << 30, fill_lo = 0, fill_hi = 0;
    logic bp_mode = 1'b0, corrupt = 1'b0;
    logic [24:0] cur_blk;
    logic [24:0] wr_addrs[$], rd_addrs[$], rq[$];
    logic prev_fet = 1'b0, prev_nf = 1'b0;
    logic [2:0] prev_cmd = '0;
    logic [24:0] prev_addr = '0;
    logic [15:0] prev_din = '0;
    logic [6:0] prev_fill = '0;
    int lfsr_exp[8] = '{32, 96, 224, 224, 192, 128, 32, 64};

    function automatic logic [15:0] e_word(input logic [24:0] a, input logic [15:0] s);
        return a[15:0] ^ s ^ {a[24:16], 7'b0};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        cyc = 0; wr_beats = 0; rd_beats = 0; wr_err = 0; proto_err = 0;
        hold_viol = 0; fill_viol = 0; ret_cnt = 0; wr_i = 0;
        wr_addrs.delete(); rd_addrs.delete(); rq.delete();
    endtask

    task automatic do_start(input logic [15:0] s);
        @(negedge clk);
        seed = s; seed_cur = s;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (cur_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_reached", 32'(cur_done), 1);
    endtask

    // Controller model: drives inputs for the next posedge and records accepted beats.
    always @(negedge clk) begin
        if (!reset) begin
            rq.delete();
            validout = 1'b0;
            prev_fet = 1'b0; prev_nf = 1'b0; prev_fill = '0;
            wr_i = 0;
        end else begin
            cyc++;
            notfull   = bp_mode ? (((cyc / 3) % 2) == 0) : 1'b1;
            fillcount = (cyc >= fill_lo && cyc < fill_hi) ? 7'd100 : 7'd10;
            ready     = !(bp_mode && cyc >= 50 && cyc < 60);
            if (prev_fet && !prev_nf && (m_fet !== prev_fet || m_cmd !== prev_cmd ||
                m_addr !== prev_addr || m_din !== prev_din))
                hold_viol++;
            if (m_fet && (!prev_fet || prev_nf) && prev_fill >= 7'd96)
                fill_viol++;
            if (m_fet && notfull) begin
                if (m_cmd == 3'b100) begin
                    if (wr_i == 0) begin
                        wr_addrs.push_back(m_addr);
                        cur_blk = m_addr;
                    end else if (m_addr != cur_blk) begin
                        wr_err++;
                    end
                    if (m_din != e_word(cur_blk + 25'(wr_i), seed_cur)) wr_err++;
                    wr_i = (wr_i + 1) % L;
                    wr_beats++;
                end else if (m_cmd == 3'b011) begin
                    rd_beats++;
                    rd_addrs.push_back(m_addr);
                end else begin
                    proto_err++;
                end
                if (m_op != 3'b000) proto_err++;
            end
            validout = 1'b0;
            if (rq.size() > 0 && ret_cnt < ret_limit) begin
                raddr = rq.pop_front();
                dout  = e_word(raddr, seed_cur) ^
                        ((corrupt && (raddr == 25'd37 || raddr == 25'd70)) ? 16'h0001 : 16'h0000);
                validout = 1'b1;
                ret_cnt++;
            end
            if (m_fet && notfull && m_cmd == 3'b011)
                for (int i = 0; i < L; i++) rq.push_back(m_addr + 25'(i));
            prev_fet = m_fet; prev_nf = notfull; prev_cmd = m_cmd;
            prev_addr = m_addr; prev_din = m_din; prev_fill = fillcount;
        end
    end

    initial begin
        clear_stats();
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_cmd", 32'(bus0.cmd), 0);
        check_eq("rst_fetching", 32'(bus0.fetching), 0);
        check_eq("rst_din", 32'(bus0.din), 0);
        check_eq("rst_addr", 32'(bus0.addr), 0);
        check_eq("rst_sz", 32'(bus0.sz), 0);
        check_eq("rst_busy", 32'(busy0), 0);
        check_eq("rst_done", 32'(done0), 0);
        check_eq("rst_pass", 32'(pass0), 0);
        check_eq("rst_err", 32'(err0), 0);
        check_eq("rst_ferr", 32'(ferr0), 0);
        check_eq("rst_timeout", 32'(tmo0), 0);
        @(negedge clk);
        reset = 1'b1;

        // sequential run, ideal controller
        clear_stats();
        do_start(16'h5A5A);
        check_eq("first_fetching", 32'(bus0.fetching), 1);
        check_eq("first_cmd", 32'(bus0.cmd), 32'h4);
        check_eq("first_addr", 32'(bus0.addr), 0);
        check_eq("first_din", 32'(bus0.din), 32'h5A5A);
        check_eq("first_sz", 32'(bus0.sz), 3);
        check_eq("first_busy", 32'(busy0), 1);
        wait_done(2000);
        check_eq("seq_pass", 32'(pass0), 1);
        check_eq("seq_err", 32'(err0), 0);
        check_eq("seq_busy", 32'(busy0), 0);
        check_eq("seq_wr_beats", 32'(wr_beats), 128);
        check_eq("seq_rd_beats", 32'(rd_beats), 4);
        for (int i = 0; i < 4; i++)
            check_eq("seq_rd_addr", (i < rd_addrs.size()) ? 32'(rd_addrs[i]) : 32'hFFFF_FFFF, 32'(i * 32));
        check_eq("seq_wr_data", 32'(wr_err), 0);
        check_eq("seq_proto", 32'(proto_err), 0);
        check_eq("seq_cmd_nop", 32'(bus0.cmd), 0);

        // backpressure, fill threshold and ready drop
        clear_stats();
        bp_mode = 1'b1; fill_lo = 10; fill_hi = 30;
        do_start(16'h1234);
        wait_done(3000);
        check_eq("bp_beats", 32'(wr_beats + rd_beats), 132);
        check_eq("bp_hold", 32'(hold_viol), 0);
        check_eq("bp_fill", 32'(fill_viol), 0);
        check_eq("bp_wr_data", 32'(wr_err), 0);
        check_eq("bp_pass", 32'(pass0), 1);
        bp_mode = 1'b0; fill_lo = 0; fill_hi = 0;

        // corrupted words at 37 and 70
        clear_stats();
        corrupt = 1'b1;
        do_start(16'hFFFF);
        wait_done(2000);
        check_eq("cor_err", 32'(err0), 2);
        check_eq("cor_first", 32'(ferr0), 37);
        check_eq("cor_pass", 32'(pass0), 0);
        check_eq("cor_timeout", 32'(tmo0), 0);
        corrupt = 1'b0;

        // last 5 words dropped
        clear_stats();
        ret_limit = 123;
        do_start(16'h0F0F);
        wait_done(6000);
        check_eq("tmo_timeout", 32'(tmo0), 1);
        check_eq("tmo_pass", 32'(pass0), 0);
        check_eq("tmo_err", 32'(err0), 0);
        ret_limit = 1 << 30;

        // reset mid-write, then a clean restart
        clear_stats();
        do_start(16'hC3C3);
        repeat (20) @(negedge clk);
        check_eq("mid_busy", 32'(busy0), 1);
        #3 reset = 1'b0;
        #1;
        check_eq("arst_cmd", 32'(bus0.cmd), 0);
        check_eq("arst_fetching", 32'(bus0.fetching), 0);
        check_eq("arst_addr", 32'(bus0.addr), 0);
        check_eq("arst_busy", 32'(busy0), 0);
        check_eq("arst_done", 32'(done0), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        clear_stats();
        do_start(16'hC3C3);
        wait_done(2000);
        check_eq("restart_pass", 32'(pass0), 1);
        check_eq("restart_wr_beats", 32'(wr_beats), 128);

        // LFSR block order on the second instance
        sel = 1'b1;
        clear_stats();
        do_start(16'hA5A5);
        wait_done(3000);
        check_eq("lfsr_pass", 32'(pass1), 1);
        check_eq("lfsr_wr_blocks", 32'(wr_addrs.size()), 8);
        check_eq("lfsr_rd_blocks", 32'(rd_addrs.size()), 8);
        for (int i = 0; i < 8; i++) begin
            check_eq("lfsr_wr_addr", (i < wr_addrs.size()) ? 32'(wr_addrs[i]) : 32'hFFFF_FFFF, 32'(lfsr_exp[i]));
            check_eq("lfsr_rd_addr", (i < rd_addrs.size()) ? 32'(rd_addrs[i]) : 32'hFFFF_FFFF, 32'(lfsr_exp[i]));
        end
        check_eq("lfsr_wr_data", 32'(wr_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
